// File: rtl/bcd_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_counter
// Brief    : Multi-digit BCD up/down counter with time-multiplexed digit scan
//            feeding a shared BCD-to-seven-segment decoder.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_scan_counter #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    up,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count_out,
    output logic                    carry,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    bcd_a,
    output logic                    bcd_b,
    output logic                    bcd_c,
    output logic                    bcd_d
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [3:0]            r_digits     [NUM_DIGITS];
    logic [3:0]            w_stepDigits [NUM_DIGITS];
    logic [3:0]            w_loadDigits [NUM_DIGITS];
    logic                  w_ripple;
    logic                  w_wrap;
    logic                  r_carry;
    logic [CNT_W-1:0]      r_scanCnt;
    logic [IDX_W-1:0]      r_scanIdx;
    logic [IDX_W-1:0]      w_nextIdx;
    logic [NUM_DIGITS-1:0] r_digitSel;
    logic [3:0]            w_scanDigit;

    // Out-of-range load nibbles are forced to 0 so the store never holds a non-BCD value.
    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            assign w_loadDigits[i]    = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
            assign count_out[4*i +: 4] = r_digits[i];
        end
    endgenerate

    // Ripple step: the pending carry/borrow propagates while digits sit at their limit.
    always_comb begin
        w_ripple = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_stepDigits[i] = r_digits[i];
            if (w_ripple) begin
                if (up) begin
                    if (r_digits[i] == 4'd9) begin
                        w_stepDigits[i] = 4'd0;
                    end else begin
                        w_stepDigits[i] = r_digits[i] + 4'd1;
                        w_ripple        = 1'b0;
                    end
                end else begin
                    if (r_digits[i] == 4'd0) begin
                        w_stepDigits[i] = 4'd9;
                    end else begin
                        w_stepDigits[i] = r_digits[i] - 4'd1;
                        w_ripple        = 1'b0;
                    end
                end
            end
        end
        w_wrap = w_ripple;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_digits[i] <= 4'd0;
            end
            r_carry <= 1'b0;
        end else if (load) begin
            r_digits <= w_loadDigits;
            r_carry  <= 1'b0;
        end else if (tick) begin
            r_digits <= w_stepDigits;
            r_carry  <= w_wrap;
        end else begin
            r_carry  <= 1'b0;
        end
    end

    assign w_nextIdx = (r_scanIdx == c_IDX_LAST) ? '0 : r_scanIdx + 1'b1;

    // Scan state is the digit index; it runs free of tick and load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scanCnt  <= '0;
            r_scanIdx  <= '0;
            r_digitSel <= NUM_DIGITS'(1);
        end else if (r_scanCnt == c_CNT_LAST) begin
            r_scanCnt  <= '0;
            r_scanIdx  <= w_nextIdx;
            r_digitSel <= NUM_DIGITS'(1) << w_nextIdx;
        end else begin
            r_scanCnt  <= r_scanCnt + 1'b1;
        end
    end

    assign w_scanDigit = r_digits[r_scanIdx];
    assign carry       = r_carry;
    assign digit_sel   = r_digitSel;
    assign {bcd_a, bcd_b, bcd_c, bcd_d} = w_scanDigit;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_scan_counter
// Brief    : Randomised bench for bcd_scan_counter against a decimal-integer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_counter;

    localparam int ND   = 4;
    localparam int SDIV = 4;
    localparam int W    = 4 * ND;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tick = 1'b0;
    logic          up = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic [W-1:0]  count_out;
    logic          carry;
    logic [ND-1:0] digit_sel;
    logic          bcd_a, bcd_b, bcd_c, bcd_d;

    int nTotal = 0;
    int nBad   = 0;

    // Reference state: count as a plain decimal integer, scan as elapsed cycles since reset.
    int modVal  = 10 ** ND;
    int mCount  = 0;
    int mCarry  = 0;
    int mScanT  = 0;

    bcd_scan_counter #(.NUM_DIGITS(ND), .SCAN_DIV(SDIV)) dut (
        .clk(clk), .rst(rst), .tick(tick), .up(up), .load(load), .load_val(load_val),
        .count_out(count_out), .carry(carry), .digit_sel(digit_sel),
        .bcd_a(bcd_a), .bcd_b(bcd_b), .bcd_c(bcd_c), .bcd_d(bcd_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTotal++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int bcdToInt(input logic [W-1:0] v);
        int r = 0;
        int n;
        for (int i = ND - 1; i >= 0; i--) begin
            n = int'(v[4*i +: 4]);
            r = r * 10 + ((n > 9) ? 0 : n);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] intToBcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int modelIdx();
        return (mScanT / SDIV) % ND;
    endfunction

    function automatic int modelDigit(input int idx);
        return (mCount / (10 ** idx)) % 10;
    endfunction

    // Drive one cycle, advance the model on the edge, then compare on the falling edge.
    task automatic cyc(input logic r, input logic l, input logic t, input logic u,
                       input logic [W-1:0] lv);
        int idx;
        rst = r; load = l; tick = t; up = u; load_val = lv;
        @(posedge clk);
        if (r) begin
            mCount = 0; mCarry = 0; mScanT = 0;
        end else begin
            mScanT++;
            if (l) begin
                mCount = bcdToInt(lv); mCarry = 0;
            end else if (t) begin
                if (u) begin
                    mCarry = (mCount == modVal - 1) ? 1 : 0;
                    mCount = (mCount + 1) % modVal;
                end else begin
                    mCarry = (mCount == 0) ? 1 : 0;
                    mCount = (mCount + modVal - 1) % modVal;
                end
            end else begin
                mCarry = 0;
            end
        end
        @(negedge clk);
        idx = modelIdx();
        chk("count_out", 32'(count_out), 32'(intToBcd(mCount)));
        chk("carry", 32'(carry), 32'(mCarry));
        chk("digit_sel", 32'(digit_sel), 32'(1) << idx);
        chk("bcd", 32'({bcd_a, bcd_b, bcd_c, bcd_d}), 32'(modelDigit(idx)));
    endtask

    initial begin
        logic [W-1:0] lv;
        int sel;
        int guard;

        cyc(1, 0, 0, 0, '0);
        cyc(0, 1, 0, 0, 16'h1239);
        cyc(0, 0, 1, 1, '0);
        cyc(0, 1, 0, 0, 16'h9999);
        cyc(0, 0, 1, 1, '0);
        cyc(0, 0, 0, 0, '0);
        cyc(0, 0, 1, 0, '0);
        cyc(0, 0, 0, 0, '0);
        cyc(0, 1, 0, 0, 16'h4321);
        for (int i = 0; i < 17; i++) cyc(0, 0, 0, 0, '0);
        cyc(0, 1, 0, 0, 16'hA5F3);
        cyc(0, 1, 1, 1, 16'h0042);
        // Reset while digit 2 is being scanned.
        guard = 0;
        while (modelIdx() != 2 && guard < 32) begin
            cyc(0, 0, 0, 0, '0);
            guard++;
        end
        chk("reach_digit2", 32'(digit_sel), 32'b0100);
        cyc(1, 0, 1, 1, 16'h9999);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, '0);

        for (int n = 0; n < 2000; n++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: lv = 16'h9999;
                1: lv = 16'h0000;
                default: lv = W'($urandom);
            endcase
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 1) == 1),
                lv);
        end

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
`default_nettype wire
